// File: rtl/bcedn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcedn_pkg
// Description : Shared constants and width helpers for the binary max/min
//               pooling block with per-channel argmax index.
// Revision    : 1.0 - initial release
// ============================================================================
package bcedn_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_MIN = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Width of an in-window index; a 1x1 window still needs one bit.
    function automatic int pindex_width(input int pool_h, input int pool_w);
        int w;
        w = clog2(pool_h * pool_w);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int cnt_width(input int n);
        int w;
        w = clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcedn_pool_lane.sv
`default_nettype none
// ============================================================================
// Module      : bcedn_pool_lane
// Description : One channel's combinational window update: running OR/AND and
//               the position of the first set (max) or clear (min) bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcedn_pool_lane
    import bcedn_pkg::*;
#(
    parameter int PIW = 2
) (
    input  logic           i_mode,
    input  logic           i_first,
    input  logic           i_pix,
    input  logic [PIW-1:0] i_pos,
    input  logic           i_val,
    input  logic [PIW-1:0] i_idx,
    output logic           o_val,
    output logic [PIW-1:0] o_idx
);

    logic w_is_min;
    logic w_hit;
    logic w_found;

    // A "hit" is the bit value that decides the result: 1 for max, 0 for min.
    assign w_is_min = (i_mode == POOL_MIN);
    assign w_hit    = i_pix ^ w_is_min;
    assign w_found  = i_val ^ w_is_min;

    always_comb begin
        o_val = i_pix;
        o_idx = '0;
        if (!i_first) begin
            o_val = w_is_min ? (i_val & i_pix) : (i_val | i_pix);
            o_idx = (!w_found && w_hit) ? i_pos : i_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcedn_maxpool_idx.sv
`default_nettype none
// ============================================================================
// Module      : bcedn_maxpool_idx
// Description : Streaming binary max/min pooling over POOL_H x POOL_W windows
//               with per-channel in-window index output, latency 1.
// Revision    : 1.0 - initial release
// ============================================================================
module bcedn_maxpool_idx
    import bcedn_pkg::*;
#(
    parameter  int W            = 8,
    parameter  int H            = 8,
    parameter  int D            = 64,
    parameter  int POOL_H       = 2,
    parameter  int POOL_W       = 2,
    localparam int PINDEX_WIDTH = pindex_width(POOL_H, POOL_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      pool_mode,
    input  logic                      in_en,
    input  logic [D-1:0]              data_in,
    output logic                      out_en,
    output logic [D-1:0]              data_out,
    output logic [D*PINDEX_WIDTH-1:0] pindex_out,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int PIW = PINDEX_WIDTH;
    localparam int WP  = W / POOL_W;
    localparam int HP  = H / POOL_H;
    localparam int SCW = cnt_width(POOL_W);
    localparam int OCW = cnt_width(WP);
    localparam int SRW = cnt_width(POOL_H);
    localparam int ORW = cnt_width(HP);

    localparam logic [SCW-1:0] c_SC_LAST  = SCW'(POOL_W - 1);
    localparam logic [OCW-1:0] c_OC_LAST  = OCW'(WP - 1);
    localparam logic [SRW-1:0] c_SR_LAST  = SRW'(POOL_H - 1);
    localparam logic [ORW-1:0] c_OR_LAST  = ORW'(HP - 1);
    localparam logic [PIW-1:0] c_POS_LAST = PIW'(POOL_H * POOL_W - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    if (POOL_H < 1 || POOL_W < 1) begin : g_bad_pool
        $error("bcedn_maxpool_idx: POOL_H and POOL_W must be at least 1");
    end
    if (W % POOL_W != 0) begin : g_bad_w
        $error("bcedn_maxpool_idx: W must be a multiple of POOL_W");
    end
    if (H % POOL_H != 0) begin : g_bad_h
        $error("bcedn_maxpool_idx: H must be a multiple of POOL_H");
    end

    logic [0:0]     r_state, w_state_nx;
    logic           r_mode;
    logic [SCW-1:0] r_sc, w_sc, w_sc_nx;
    logic [OCW-1:0] r_oc, w_oc, w_oc_nx;
    logic [SRW-1:0] r_sr, w_sr, w_sr_nx;
    logic [ORW-1:0] r_or, w_or, w_or_nx;

    logic [D-1:0]     r_buf_val [WP];
    logic [D*PIW-1:0] r_buf_idx [WP];

    logic             w_accept;
    logic             w_mode;
    logic [PIW-1:0]   w_pos;
    logic             w_first;
    logic             w_last;
    logic             w_frame_last;
    logic [D-1:0]     w_rd_val, w_nx_val;
    logic [D*PIW-1:0] w_rd_idx, w_nx_idx;

    assign busy     = (r_state == S_RUN);
    assign w_accept = in_en && (busy || start);

    // A start pulse makes the coincident pixel row 0, col 0 of a fresh frame.
    assign w_mode = start ? pool_mode : r_mode;
    assign w_sc   = start ? '0 : r_sc;
    assign w_oc   = start ? '0 : r_oc;
    assign w_sr   = start ? '0 : r_sr;
    assign w_or   = start ? '0 : r_or;

    assign w_pos        = PIW'(w_sr) * PIW'(POOL_W) + PIW'(w_sc);
    assign w_first      = (w_pos == '0);
    assign w_last       = (w_pos == c_POS_LAST);
    assign w_frame_last = w_last && (w_oc == c_OC_LAST) && (w_or == c_OR_LAST);

    assign w_rd_val = r_buf_val[w_oc];
    assign w_rd_idx = r_buf_idx[w_oc];

    for (genvar k = 0; k < D; k++) begin : g_lane
        bcedn_pool_lane #(
            .PIW (PIW)
        ) u_lane (
            .i_mode  (w_mode),
            .i_first (w_first),
            .i_pix   (data_in[k]),
            .i_pos   (w_pos),
            .i_val   (w_rd_val[k]),
            .i_idx   (w_rd_idx[k*PIW +: PIW]),
            .o_val   (w_nx_val[k]),
            .o_idx   (w_nx_idx[k*PIW +: PIW])
        );
    end

    always_comb begin
        w_sc_nx = w_sc;
        w_oc_nx = w_oc;
        w_sr_nx = w_sr;
        w_or_nx = w_or;
        if (w_accept) begin
            if (w_sc != c_SC_LAST) begin
                w_sc_nx = w_sc + SCW'(1);
            end else begin
                w_sc_nx = '0;
                if (w_oc != c_OC_LAST) begin
                    w_oc_nx = w_oc + OCW'(1);
                end else begin
                    w_oc_nx = '0;
                    if (w_sr != c_SR_LAST) begin
                        w_sr_nx = w_sr + SRW'(1);
                    end else begin
                        w_sr_nx = '0;
                        w_or_nx = (w_or != c_OR_LAST) ? w_or + ORW'(1) : '0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (start) begin
            w_state_nx = S_RUN;
        end
        if (w_accept && w_frame_last) begin
            w_state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= POOL_MAX;
            r_sc       <= '0;
            r_oc       <= '0;
            r_sr       <= '0;
            r_or       <= '0;
            out_en     <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
            pindex_out <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_sc       <= w_sc_nx;
            r_oc       <= w_oc_nx;
            r_sr       <= w_sr_nx;
            r_or       <= w_or_nx;
            out_en     <= w_accept && w_last;
            frame_done <= w_accept && w_frame_last;
            if (start) begin
                r_mode <= pool_mode;
            end
            if (w_accept && w_last) begin
                data_out   <= w_nx_val;
                pindex_out <= w_nx_idx;
            end
        end
    end

    // The p==0 pixel always overwrites its entry, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_buf_val[w_oc] <= w_nx_val;
            r_buf_idx[w_oc] <= w_nx_idx;
        end
    end

endmodule
`default_nettype wire
